// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NREQ load/store units; one access in flight.
// Latency: request -> hit in 2 cycles minimum (IDLE, ACCESS, DONE); requesters stall by holding REN/WEN until hit.
// Optional macro ARB_LOCK_EN lets the current owner keep the port across accesses via req_lock.
module dmem_port_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NREQ-1:0]        req_ren,
  input  logic [NREQ-1:0]        req_wen,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_store,
  input  logic [NREQ-1:0]        req_lock,
  output logic [NREQ-1:0]        req_hit,
  output logic [DATA_W-1:0]      req_load,
  output logic                   mem_ren,
  output logic                   mem_wen,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_store,
  input  logic [DATA_W-1:0]      mem_load,
  input  logic                   mem_ready,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy
);

`ifdef ARB_LOCK_EN
  localparam logic LOCK_EN = 1'b1;
`else
  localparam logic LOCK_EN = 1'b0;
`endif

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]        state;
  logic [IDW-1:0]    owner;
  logic [IDW-1:0]    last;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q;
  logic              wr_q;
  logic [DATA_W-1:0] load_q;
  logic              lock_q;

  logic [NREQ-1:0]   active;
  logic              win_vld;
  logic [IDW-1:0]    win_id;
  logic [IDW-1:0]    cand;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_store;
  logic              in_access;
  logic              in_done;

  assign active = req_ren | req_wen;

  // Scan starts one past the last owner so every active requester is served within NREQ grants.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(last) + i) % NREQ);
      if (!win_vld && active[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
    if (LOCK_EN && lock_q && active[owner]) begin
      win_vld = 1'b1;
      win_id  = owner;
    end
  end

  assign win_addr  = req_addr[win_id*ADDR_W +: ADDR_W];
  assign win_store = req_store[win_id*DATA_W +: DATA_W];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      owner   <= '0;
      last    <= IDW'(NREQ - 1);
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      load_q  <= '0;
      lock_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A held lock is consumed here; DONE re-arms it if the owner still asks.
          lock_q <= 1'b0;
          if (win_vld) begin
            owner   <= win_id;
            addr_q  <= win_addr;
            store_q <= win_store;
            wr_q    <= req_wen[win_id];
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            if (!wr_q) load_q <= mem_load;
            state <= DONE;
          end
        end
        DONE: begin
          last   <= owner;
          lock_q <= LOCK_EN & req_lock[owner];
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_access = (state == ACCESS);
  assign in_done   = (state == DONE);

  assign mem_ren   = in_access & ~wr_q;
  assign mem_wen   = in_access & wr_q;
  assign mem_addr  = in_access ? addr_q  : '0;
  assign mem_store = in_access ? store_q : '0;

  always_comb begin
    req_hit = '0;
    if (in_done) req_hit[owner] = 1'b1;
  end

  // Writes leave load_q untouched, so a write hit presents the previous read data.
  assign req_load = in_done ? load_q : '0;
  assign grant_id = owner;
  assign busy     = (state != IDLE);

endmodule
